// File: rtl/axis_result_buffer.sv
//==============================================================================
// Module   : axis_result_buffer
// Purpose  : Credit-managed first-word-fall-through FIFO that buffers adder
//            results and presents them on an AXI-Stream master port.
//            Upstream is credited only for FIFO space not already claimed by
//            stored results or by operand pairs still inside the adder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_result_buffer #(
    parameter int WIDTH = 4,   // adder operand width; results are WIDTH+1 bits
    parameter int DEPTH = 4    // FIFO entries, power of two, at least 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_i,
    input  logic                     valid_i,
    input  logic [WIDTH:0]           data_i,
    output logic                     credit_o,
    output logic [WIDTH:0]           m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [CW-1:0] ONE          = CW'(1);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic            overflow;

    logic            full;
    logic            pop;
    logic            wr_en;
    logic            drop;
    logic [CW:0]     committed;

    // Handshake decode. A full FIFO still accepts a write when the head
    // leaves in the same cycle, since the freed slot is reused at once.
    always_comb begin
        full      = (count == FULL_COUNT);
        pop       = (count != '0) && m_axis_tready;
        wr_en     = valid_i && (!full || pop);
        drop      = valid_i && full && !pop;
        committed = {1'b0, count} + {1'b0, inflight};
    end

    // Storage array; contents need no reset because occupancy gates tvalid.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy. Pointers are log2(DEPTH) wide so they wrap
    // from DEPTH-1 to 0 naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // In-flight tracker: results promised by the adder but not yet returned.
    // Saturates at both ends so protocol violations cannot wrap it.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else if (issue_i && !valid_i) begin
            if (inflight != FULL_COUNT) begin
                inflight <= inflight + ONE;
            end
        end else if (valid_i && !issue_i) begin
            if (inflight != '0) begin
                inflight <= inflight - ONE;
            end
        end
    end

    // Sticky overflow flag: set when a result is dropped, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Outputs. Credit uses registered state only, so a pop in the current
    // cycle is credited one cycle later.
    always_comb begin
        credit_o      = (committed < CREDIT_LIMIT);
        m_axis_tvalid = (count != '0);
        m_axis_tdata  = mem[rd_ptr];
        count_o       = count;
        overflow_o    = overflow;
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_result_buffer.sv
//==============================================================================
// Module   : tb_axis_result_buffer
// Purpose  : Self-checking bench for axis_result_buffer: directed scenarios
//            plus randomized traffic compared against a queue-based model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axis_result_buffer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    typedef logic [WIDTH:0] word_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   issue_i = 1'b0;
    logic                   valid_i = 1'b0;
    word_t                  data_i = '0;
    logic                   credit_o;
    word_t                  m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b0;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents as a queue, in-flight count, sticky flag.
    word_t mq[$];
    int    m_inflight = 0;
    bit    m_ovf = 1'b0;

    axis_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_i       (issue_i),
        .valid_i       (valid_i),
        .data_i        (data_i),
        .credit_o      (credit_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model on the clock edge,
    // and return 1 time unit after the edge.
    task automatic cycle(input bit iss, input bit val, input word_t d,
                         input bit rdy, input bit rst);
        bit popped;
        issue_i       = iss;
        valid_i       = val;
        data_i        = d;
        m_axis_tready = rdy;
        reset         = rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_inflight = 0;
            m_ovf      = 1'b0;
        end else begin
            popped = (mq.size() != 0) && rdy;
            if (val && mq.size() == DEPTH && !popped) m_ovf = 1'b1;
            else if (val && !popped) mq.push_back(d);
            else if (val && popped) begin
                void'(mq.pop_front());
                mq.push_back(d);
            end else if (popped) void'(mq.pop_front());
            if (iss && !val && m_inflight < DEPTH) m_inflight++;
            if (val && !iss && m_inflight > 0) m_inflight--;
        end
        #1;
    endtask

    task automatic fill_1_to_4();
        for (int k = 1; k <= 4; k++) cycle(0, 1, word_t'(k), 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 1, 5'd5, 1, 1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); end
        checks++; if (count_o !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++; if (credit_o !== 1'b1) begin errors++; $display("FAIL reset_credit: got %0b want 1", credit_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
    endtask

    task automatic test_single();
        cycle(0, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_early_tvalid: got %0b want 0", m_axis_tvalid); end
        cycle(0, 1, 5'd5, 1, 0);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 5'd5) begin
            errors++; $display("FAIL single_out: got v=%0b d=%0d want v=1 d=5", m_axis_tvalid, m_axis_tdata); end
        cycle(0, 0, 0, 1, 0);
        checks++; if (count_o !== 0 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL single_drained: got count=%0d v=%0b want 0 0", count_o, m_axis_tvalid); end
    endtask

    task automatic test_fill_drain();
        cycle(0, 0, 0, 0, 1);
        fill_1_to_4();
        cycle(0, 0, 0, 0, 0);
        checks++; if (count_o !== 4 || credit_o !== 1'b0 || m_axis_tdata !== 5'd1) begin
            errors++; $display("FAIL full_hold: got count=%0d credit=%0b d=%0d want 4 0 1", count_o, credit_o, m_axis_tdata); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_t'(k)) begin
                errors++; $display("FAIL drain_%0d: got v=%0b d=%0d want v=1 d=%0d", k, m_axis_tvalid, m_axis_tdata, k); end
            cycle(0, 0, 0, 1, 0);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b want 0", m_axis_tvalid); end
    endtask

    task automatic test_full_write_pop();
        word_t exp[4] = '{5'd2, 5'd3, 5'd4, 5'd31};
        cycle(0, 0, 0, 0, 1);
        fill_1_to_4();
        cycle(0, 1, 5'd31, 1, 0);
        checks++; if (count_o !== 4 || overflow_o !== 1'b0) begin
            errors++; $display("FAIL full_wr_pop: got count=%0d ovf=%0b want 4 0", count_o, overflow_o); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (m_axis_tdata !== exp[k] || m_axis_tvalid !== 1'b1) begin
                errors++; $display("FAIL full_wr_order_%0d: got d=%0d want %0d", k, m_axis_tdata, exp[k]); end
            cycle(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_overflow();
        cycle(0, 0, 0, 0, 1);
        fill_1_to_4();
        cycle(0, 1, 5'd9, 0, 0);
        checks++; if (overflow_o !== 1'b1 || count_o !== 4) begin
            errors++; $display("FAIL ovf_set: got ovf=%0b count=%0d want 1 4", overflow_o, count_o); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (m_axis_tdata !== word_t'(k)) begin
                errors++; $display("FAIL ovf_order_%0d: got d=%0d want %0d", k, m_axis_tdata, k); end
            cycle(0, 0, 0, 1, 0);
        end
        checks++; if (m_axis_tvalid !== 1'b0 || overflow_o !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got v=%0b ovf=%0b want 0 1", m_axis_tvalid, overflow_o); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow_o); end
    endtask

    task automatic test_credit();
        cycle(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 5'd7, 0, 0);
        cycle(0, 1, 5'd8, 0, 0);
        checks++; if (credit_o !== 1'b0 || count_o !== 2) begin
            errors++; $display("FAIL credit_busy: got credit=%0b count=%0d want 0 2", credit_o, count_o); end
        m_axis_tready = 1'b1;
        #1;
        checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL credit_pop_cycle: got %0b want 0", credit_o); end
        cycle(0, 0, 0, 1, 0);
        checks++; if (credit_o !== 1'b1 || count_o !== 1) begin
            errors++; $display("FAIL credit_after_pop: got credit=%0b count=%0d want 1 1", credit_o, count_o); end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, word_t'(k + 11), 0, 0);
        cycle(1, 1, 5'd20, 1, 1);
        checks++; if (m_axis_tvalid !== 1'b0 || count_o !== 0 || credit_o !== 1'b1 || overflow_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got v=%0b count=%0d credit=%0b ovf=%0b want 0 0 1 0",
                               m_axis_tvalid, count_o, credit_o, overflow_o); end
        cycle(0, 1, 5'd6, 0, 0);
        checks++; if (count_o !== 1 || m_axis_tdata !== 5'd6 || credit_o !== 1'b1) begin
            errors++; $display("FAIL late_result: got count=%0d d=%0d credit=%0b want 1 6 1", count_o, m_axis_tdata, credit_o); end
    endtask

    task automatic test_wrap();
        word_t w;
        cycle(0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            w = word_t'(3 * k + 1);
            cycle(0, 1, w, 0, 0);
            checks++; if (m_axis_tdata !== w || count_o !== 1) begin
                errors++; $display("FAIL wrap_%0d: got d=%0d count=%0d want %0d 1", k, m_axis_tdata, count_o, w); end
            cycle(0, 0, 0, 1, 0);
        end
        checks++; if (count_o !== 0) begin errors++; $display("FAIL wrap_end: got %0d want 0", count_o); end
    endtask

    task automatic test_random();
        bit iss, val, rdy, rst;
        int bad = 0;
        cycle(0, 0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            iss = credit_o ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            val = ($urandom_range(0, 2) != 0);
            rdy = ((n / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle(iss, val, word_t'($urandom), rdy, rst);
            checks++;
            if (m_axis_tvalid !== (mq.size() != 0) || count_o !== mq.size() ||
                credit_o !== ((mq.size() + m_inflight) < DEPTH) || overflow_o !== m_ovf ||
                (mq.size() != 0 && m_axis_tdata !== mq[0])) begin
                errors++;
                if (bad < 10) $display("FAIL random_cyc%0d: got v=%0b c=%0d cr=%0b o=%0b d=%0d want v=%0b c=%0d cr=%0b o=%0b d=%0d",
                    n, m_axis_tvalid, count_o, credit_o, overflow_o, m_axis_tdata,
                    mq.size() != 0, mq.size(), (mq.size() + m_inflight) < DEPTH, m_ovf,
                    (mq.size() != 0) ? mq[0] : word_t'(0));
                bad++;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_full_write_pop();
        test_overflow();
        test_credit();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_result_buffer.md
AXIS_RESULT_BUFFER -- requirements
Module: axis_result_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand width of the upstream adder; result width is WIDTH+1.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, minimum 4.
REQ-003 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port issue_i  input  1  high for one cycle per operand pair launched into the adder.
REQ-006 The block SHALL have port valid_i  input  1  adder result strobe.
REQ-007 The block SHALL have port data_i  input  WIDTH+1  adder sum, qualified by valid_i.
REQ-008 The block SHALL have port credit_o  output  1  high means upstream may assert issue_i this cycle.
REQ-009 The block SHALL have port m_axis_tdata  output  WIDTH+1  head-of-FIFO sum.
REQ-010 The block SHALL have port m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 The block SHALL have port m_axis_tready  input  1  AXI-Stream ready.
REQ-012 The block SHALL have port count_o  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 The block SHALL have port overflow_o  output  1  sticky error: a result was dropped.

Function
REQ-014 The block SHALL store each valid_i result in a DEPTH-entry FIFO, in arrival order, data_i captured unmodified.
REQ-015 The FIFO SHALL be first-word fall-through: m_axis_tvalid = (count != 0); m_axis_tdata = oldest entry, stable while tvalid high and tready low.
REQ-016 A pop SHALL occur on a cycle with m_axis_tvalid and m_axis_tready both high; pointer advances at that clock edge.
REQ-017 A write SHALL be accepted when valid_i is high and (count < DEPTH or a pop occurs the same cycle).
REQ-018 Simultaneous accepted write and pop SHALL leave count unchanged; write with empty FIFO makes data visible on tvalid the following cycle (no combinational bypass).
REQ-019 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 The block SHALL keep an in-flight counter (0..DEPTH): +1 on issue_i, -1 on valid_i, unchanged when both high; decrement at 0 saturates at 0.
REQ-021 credit_o SHALL be combinational: high iff count + inflight < DEPTH, using registered values only (pop in the current cycle not credited).
REQ-022 valid_i when full with no same-cycle pop SHALL drop data_i, leave FIFO contents unchanged, and set overflow_o from the next cycle until reset.
REQ-023 issue_i asserted while credit_o low SHALL still increment inflight (saturating at DEPTH); protocol violation, no other effect.
REQ-024 count_o SHALL equal registered occupancy, 0..DEPTH.

Reset
REQ-025 On reset high at a clock edge: pointers, count, inflight = 0; overflow_o = 0; m_axis_tvalid = 0; credit_o = 1 the following cycle.
REQ-026 Reset SHALL take priority over issue_i, valid_i and pop in the same cycle; FIFO contents discarded, m_axis_tdata don't-care while tvalid low.
REQ-027 Reset mid-transfer SHALL drop all stored and in-flight results; results arriving after reset from pre-reset issues are counted as new writes.

Verification
REQ-028 WIDTH=4, DEPTH=4, tready=1: issue_i then valid_i two cycles later with data_i=5 -> tvalid high one cycle after valid_i with tdata=5, count returns to 0 after pop.
REQ-029 tready=0, four results 1,2,3,4 -> count_o=4, credit_o=0, tdata=1 held; tready=1 -> outputs 1,2,3,4 on consecutive cycles, then tvalid=0.
REQ-030 Full FIFO, tready=1 and valid_i with data_i=31 same cycle -> write accepted, count stays 4, overflow_o stays 0, 31 emerges last.
REQ-031 Full FIFO, tready=0, valid_i with data_i=9 -> 9 never emitted, overflow_o=1 next cycle and held until reset.
REQ-032 count=2, inflight=2 -> credit_o=0; one pop -> credit_o still 0 that cycle, 1 the next.
REQ-033 Reset asserted with count=3, inflight=1 -> next cycle tvalid=0, count_o=0, credit_o=1, overflow_o=0; wrap test: 10 write/pop pairs return data in order.
